// File: rtl/ex_lsu_stage_pkg.sv
// Shared types for the EX load/store slot: memory op kinds, access sizes,
// MMU size encodings and the orphan-drain state machine states.
package ex_lsu_stage_pkg;

    typedef enum logic [1:0] {
        MEM_NOP    = 2'd0,
        MEM_LOAD_S = 2'd1,
        MEM_LOAD_U = 2'd2,
        MEM_STORE  = 2'd3
    } mem_type_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    localparam logic [1:0] MMU_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MMU_SIZE_HALF = 2'd1;
    localparam logic [1:0] MMU_SIZE_WORD = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } lsu_state_t;

    // Translate the pipeline access size into the MMU size field.
    function automatic logic [1:0] mmu_size_of(input mem_size_t size);
        logic [1:0] enc;
        case (size)
            MEM_BYTE: enc = MMU_SIZE_BYTE;
            MEM_HALF: enc = MMU_SIZE_HALF;
            MEM_WORD: enc = MMU_SIZE_WORD;
            default:  enc = MMU_SIZE_WORD;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/ex_lsu_stage_store_align.sv
// Store data replication and byte-strobe generation for the MMU write port.
// Loads and non-memory ops produce an all-zero strobe.
module ex_lsu_stage_store_align
    import ex_lsu_stage_pkg::*;
(
    input  logic        is_store,
    input  mem_size_t   size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [31:0] mmu_wdata,
    output logic [3:0]  mmu_wstrb
);

    // Replicate the low bytes across the word and pick the lanes being written.
    always_comb begin
        mmu_wdata = wdata;
        mmu_wstrb = 4'b0000;
        case (size)
            MEM_BYTE: begin
                mmu_wdata = {4{wdata[7:0]}};
                mmu_wstrb = 4'b0001 << addr_lo;
            end
            MEM_HALF: begin
                mmu_wdata = {2{wdata[15:0]}};
                mmu_wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            MEM_WORD: begin
                mmu_wdata = wdata;
                mmu_wstrb = 4'b1111;
            end
            default: begin
                mmu_wdata = wdata;
                mmu_wstrb = 4'b0000;
            end
        endcase
        if (!is_store) begin
            mmu_wstrb = 4'b0000;
        end else begin
            mmu_wstrb = mmu_wstrb;
        end
    end

endmodule

// File: rtl/ex_lsu_stage.sv
// EX-stage pipeline register for the memory slot. Forms the effective
// address, issues at most one MMU request per instruction (only when the
// instruction can leave EX on the same edge), and drains a request whose
// owner was flushed so its late data_ok never reaches a younger load.
module ex_lsu_stage
    import ex_lsu_stage_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        id_valid,
    output logic        ex_allowin,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_result,
    input  logic [4:0]  id_dest,
    input  logic [31:0] id_base,
    input  logic [31:0] id_offset,
    input  logic [31:0] id_wdata,
    input  mem_type_t   id_mem_type,
    input  mem_size_t   id_mem_size,
    input  logic        alu_ready,
    input  logic        mem_stall,
    output logic        ex_valid,
    output logic        ex_both_ready,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_result,
    output logic [31:0] ex_addr,
    output logic [4:0]  ex_dest,
    output mem_type_t   ex_mem_type,
    output mem_size_t   ex_mem_size,
    output logic        ex_got_data_ok,
    output logic [31:0] ex_ld_data,
    output logic        mmu_req,
    output logic        mmu_we,
    output logic [1:0]  mmu_size,
    output logic [31:0] mmu_addr,
    output logic [3:0]  mmu_wstrb,
    output logic [31:0] mmu_wdata,
    input  logic        mmu_addr_ok,
    input  logic        mmu_data_ok,
    input  logic [31:0] mmu_rdata
);

    logic        ex_valid_q,  ex_valid_d;
    logic [31:0] ex_pc_q,     ex_pc_d;
    logic [31:0] ex_result_q, ex_result_d;
    logic [4:0]  ex_dest_q,   ex_dest_d;
    logic [31:0] ex_base_q,   ex_base_d;
    logic [31:0] ex_offset_q, ex_offset_d;
    logic [31:0] ex_wdata_q,  ex_wdata_d;
    mem_type_t   ex_type_q,   ex_type_d;
    mem_size_t   ex_size_q,   ex_size_d;
    lsu_state_t  state_q,     state_d;
    logic        pend_q,      pend_d;

    logic [31:0] addr_s;
    logic        is_mem_s;
    logic        req_s;
    logic        both_ready_s;
    logic        allowin_s;

    // Address, issue gating, readiness and same-cycle response capture.
    always_comb begin
        addr_s       = ex_base_q + ex_offset_q;
        is_mem_s     = (ex_type_q != MEM_NOP);
        req_s        = ex_valid_q && is_mem_s && alu_ready && !mem_stall
                       && (state_q == S_IDLE) && !flush;
        both_ready_s = alu_ready && (!is_mem_s || (req_s && mmu_addr_ok));
        allowin_s    = !ex_valid_q || (both_ready_s && !mem_stall);
    end

    assign ex_valid       = ex_valid_q;
    assign ex_allowin     = allowin_s;
    assign ex_both_ready  = both_ready_s;
    assign ex_pc          = ex_pc_q;
    assign ex_result      = ex_result_q;
    assign ex_addr        = addr_s;
    assign ex_dest        = ex_dest_q;
    assign ex_mem_type    = ex_type_q;
    assign ex_mem_size    = ex_size_q;
    assign ex_got_data_ok = req_s && mmu_addr_ok && mmu_data_ok;
    assign ex_ld_data     = mmu_rdata;
    assign mmu_req        = req_s;
    assign mmu_we         = ex_valid_q && (ex_type_q == MEM_STORE);
    assign mmu_size       = mmu_size_of(ex_size_q);
    assign mmu_addr       = addr_s;

    ex_lsu_stage_store_align u_store_align (
        .is_store  (ex_type_q == MEM_STORE),
        .size      (ex_size_q),
        .addr_lo   (addr_s[1:0]),
        .wdata     (ex_wdata_q),
        .mmu_wdata (mmu_wdata),
        .mmu_wstrb (mmu_wstrb)
    );

    // Next-state of the EX pipeline register: flush kills, else load on allowin.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_pc_d     = ex_pc_q;
        ex_result_d = ex_result_q;
        ex_dest_d   = ex_dest_q;
        ex_base_d   = ex_base_q;
        ex_offset_d = ex_offset_q;
        ex_wdata_d  = ex_wdata_q;
        ex_type_d   = ex_type_q;
        ex_size_d   = ex_size_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (allowin_s) begin
            ex_valid_d = id_valid;
            if (id_valid) begin
                ex_pc_d     = id_pc;
                ex_result_d = id_result;
                ex_dest_d   = id_dest;
                ex_base_d   = id_base;
                ex_offset_d = id_offset;
                ex_wdata_d  = id_wdata;
                ex_type_d   = id_mem_type;
                ex_size_d   = id_mem_size;
            end else begin
                ex_pc_d = ex_pc_q;
            end
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // Orphan tracking: pend follows the accepted request now owned by MEM;
    // a flush while it is pending moves to DRAIN until its data_ok arrives.
    always_comb begin
        pend_d  = pend_q;
        state_d = state_q;
        if (req_s && mmu_addr_ok && !mmu_data_ok) begin
            pend_d = 1'b1;
        end else if (mmu_data_ok) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        case (state_q)
            S_IDLE: begin
                if (flush && pend_q && !mmu_data_ok) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mmu_data_ok) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pipeline register and drain FSM state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ex_valid_q  <= 1'b0;
            ex_pc_q     <= 32'd0;
            ex_result_q <= 32'd0;
            ex_dest_q   <= 5'd0;
            ex_base_q   <= 32'd0;
            ex_offset_q <= 32'd0;
            ex_wdata_q  <= 32'd0;
            ex_type_q   <= MEM_NOP;
            ex_size_q   <= MEM_BYTE;
            state_q     <= S_IDLE;
            pend_q      <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_pc_q     <= ex_pc_d;
            ex_result_q <= ex_result_d;
            ex_dest_q   <= ex_dest_d;
            ex_base_q   <= ex_base_d;
            ex_offset_q <= ex_offset_d;
            ex_wdata_q  <= ex_wdata_d;
            ex_type_q   <= ex_type_d;
            ex_size_q   <= ex_size_d;
            state_q     <= state_d;
            pend_q      <= pend_d;
        end
    end

endmodule

// File: tb/tb_ex_lsu_stage.sv
// Self-checking bench for ex_lsu_stage: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_ex_lsu_stage;
    import ex_lsu_stage_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, flush, id_valid, alu_ready, mem_stall;
    logic [31:0] id_pc, id_result, id_base, id_offset, id_wdata;
    logic [4:0]  id_dest;
    mem_type_t   id_mem_type;
    mem_size_t   id_mem_size;
    logic        mmu_addr_ok, mmu_data_ok;
    logic [31:0] mmu_rdata;
    logic        ex_allowin, ex_valid, ex_both_ready, ex_got_data_ok;
    logic [31:0] ex_pc, ex_result, ex_addr, ex_ld_data;
    logic [4:0]  ex_dest;
    mem_type_t   ex_mem_type;
    mem_size_t   ex_mem_size;
    logic        mmu_req, mmu_we;
    logic [1:0]  mmu_size;
    logic [31:0] mmu_addr, mmu_wdata;
    logic [3:0]  mmu_wstrb;

    always #5 clk = ~clk;

    ex_lsu_stage dut (
        .clk(clk), .resetn(resetn), .flush(flush), .id_valid(id_valid),
        .ex_allowin(ex_allowin), .id_pc(id_pc), .id_result(id_result),
        .id_dest(id_dest), .id_base(id_base), .id_offset(id_offset),
        .id_wdata(id_wdata), .id_mem_type(id_mem_type), .id_mem_size(id_mem_size),
        .alu_ready(alu_ready), .mem_stall(mem_stall), .ex_valid(ex_valid),
        .ex_both_ready(ex_both_ready), .ex_pc(ex_pc), .ex_result(ex_result),
        .ex_addr(ex_addr), .ex_dest(ex_dest), .ex_mem_type(ex_mem_type),
        .ex_mem_size(ex_mem_size), .ex_got_data_ok(ex_got_data_ok),
        .ex_ld_data(ex_ld_data), .mmu_req(mmu_req), .mmu_we(mmu_we),
        .mmu_size(mmu_size), .mmu_addr(mmu_addr), .mmu_wstrb(mmu_wstrb),
        .mmu_wdata(mmu_wdata), .mmu_addr_ok(mmu_addr_ok),
        .mmu_data_ok(mmu_data_ok), .mmu_rdata(mmu_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: the instruction held in EX, whether an accepted
    // request is still awaiting its response, and whether that response
    // belongs to an instruction that has been flushed.
    typedef struct {
        bit          v;
        logic [31:0] pc, res, base, off, wd;
        logic [4:0]  dest;
        mem_type_t   typ;
        mem_size_t   size;
    } ex_slot_t;

    ex_slot_t m_ex;
    bit       m_outstanding;
    bit       m_orphan;

    task automatic model_reset();
        m_ex.v = 1'b0; m_ex.pc = 32'd0; m_ex.res = 32'd0; m_ex.base = 32'd0;
        m_ex.off = 32'd0; m_ex.wd = 32'd0; m_ex.dest = 5'd0;
        m_ex.typ = MEM_NOP; m_ex.size = MEM_BYTE;
        m_outstanding = 1'b0;
        m_orphan = 1'b0;
    endtask

    function automatic bit model_req();
        return m_ex.v && (m_ex.typ != MEM_NOP) && alu_ready && !mem_stall
               && !m_orphan && !flush;
    endfunction

    // One clock: optionally pick MMU responses, check outputs mid-cycle,
    // then advance the model on the rising edge. Entered just after a falling edge.
    task automatic run_cycle(input bit rand_mmu);
        bit          e_req, e_both, e_allow, e_got, e_acc;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        logic [1:0]  e_size;
        e_req = model_req();
        if (rand_mmu) begin
            mmu_addr_ok = !m_outstanding && ($urandom_range(0, 1) == 1);
            mmu_data_ok = (m_outstanding || (e_req && mmu_addr_ok)) && ($urandom_range(0, 2) != 0);
            mmu_rdata   = $urandom;
        end
        #1;
        e_addr  = m_ex.base + m_ex.off;
        e_both  = alu_ready && ((m_ex.typ == MEM_NOP) || (e_req && mmu_addr_ok));
        e_allow = !m_ex.v || (e_both && !mem_stall);
        e_got   = e_req && mmu_addr_ok && mmu_data_ok;
        e_size  = (m_ex.size == MEM_BYTE) ? 2'd0 : (m_ex.size == MEM_HALF) ? 2'd1 : 2'd2;
        if (m_ex.size == MEM_BYTE) begin
            e_wdata = {24'd0, m_ex.wd[7:0]} * 32'h0101_0101;
            e_wstrb = 4'(1 << e_addr[1:0]);
        end else if (m_ex.size == MEM_HALF) begin
            e_wdata = {16'd0, m_ex.wd[15:0]} * 32'h0001_0001;
            e_wstrb = e_addr[1] ? 4'hC : 4'h3;
        end else begin
            e_wdata = m_ex.wd;
            e_wstrb = 4'hF;
        end
        check_val("ex_valid", 32'(ex_valid), 32'(m_ex.v));
        check_val("mmu_req", 32'(mmu_req), 32'(e_req));
        check_val("ex_allowin", 32'(ex_allowin), 32'(e_allow));
        check_val("ex_both_ready", 32'(ex_both_ready), 32'(e_both));
        check_val("ex_got_data_ok", 32'(ex_got_data_ok), 32'(e_got));
        check_val("ex_addr", ex_addr, e_addr);
        check_val("mmu_addr", mmu_addr, e_addr);
        if (m_ex.v) begin
            check_val("ex_pc", ex_pc, m_ex.pc);
            check_val("ex_result", ex_result, m_ex.res);
            check_val("ex_dest", 32'(ex_dest), 32'(m_ex.dest));
            check_val("ex_mem_type", 32'(ex_mem_type), 32'(m_ex.typ));
            check_val("ex_mem_size", 32'(ex_mem_size), 32'(m_ex.size));
        end
        if (e_req) begin
            check_val("mmu_we", 32'(mmu_we), 32'(m_ex.typ == MEM_STORE));
            check_val("mmu_size", 32'(mmu_size), 32'(e_size));
            if (m_ex.typ == MEM_STORE) begin
                check_val("mmu_wstrb", 32'(mmu_wstrb), 32'(e_wstrb));
                check_val("mmu_wdata", mmu_wdata, e_wdata);
            end else begin
                check_val("mmu_wstrb_ld", 32'(mmu_wstrb), 32'd0);
            end
        end
        if (e_got) check_val("ex_ld_data", ex_ld_data, mmu_rdata);
        @(posedge clk);
        if (!resetn) begin
            model_reset();
        end else begin
            e_acc = e_req && mmu_addr_ok;
            if (flush && m_outstanding && !mmu_data_ok) m_orphan = 1'b1;
            if (mmu_data_ok) begin
                m_outstanding = 1'b0;
                m_orphan = 1'b0;
            end
            if (e_acc && !mmu_data_ok) m_outstanding = 1'b1;
            if (flush) begin
                m_ex.v = 1'b0;
            end else if (e_allow) begin
                m_ex.v = id_valid;
                if (id_valid) begin
                    m_ex.pc = id_pc; m_ex.res = id_result; m_ex.dest = id_dest;
                    m_ex.base = id_base; m_ex.off = id_offset; m_ex.wd = id_wdata;
                    m_ex.typ = id_mem_type; m_ex.size = id_mem_size;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_id(input bit v, input mem_type_t t, input mem_size_t s,
                            input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd);
        id_valid = v; id_mem_type = t; id_mem_size = s;
        id_base = base; id_offset = off; id_wdata = wd;
        id_pc = $urandom; id_result = $urandom; id_dest = 5'($urandom);
    endtask

    task automatic idle_mmu();
        mmu_addr_ok = 1'b0; mmu_data_ok = 1'b0; mmu_rdata = 32'd0;
    endtask

    initial begin
        logic [31:0] b, o, a;
        mem_size_t   sz;
        resetn = 1'b0; flush = 1'b0; alu_ready = 1'b1; mem_stall = 1'b0;
        drive_id(1'b0, MEM_NOP, MEM_BYTE, 32'd0, 32'd0, 32'd0);
        idle_mmu();
        model_reset();
        @(negedge clk);
        // Reset state.
        check_val("rst_ex_valid", 32'(ex_valid), 32'd0);
        check_val("rst_mmu_req", 32'(mmu_req), 32'd0);
        check_val("rst_got", 32'(ex_got_data_ok), 32'd0);
        run_cycle(1'b0);
        resetn = 1'b1;

        // Load word, response in the issue cycle.
        drive_id(1'b1, MEM_LOAD_S, MEM_WORD, 32'h1000, 32'h4, 32'd0);
        run_cycle(1'b0);
        drive_id(1'b0, MEM_NOP, MEM_BYTE, 32'd0, 32'd0, 32'd0);
        mmu_addr_ok = 1'b1; mmu_data_ok = 1'b1; mmu_rdata = 32'hDEAD_BEEF;
        #1;
        check_val("t1_addr", mmu_addr, 32'h1004);
        check_val("t1_got", 32'(ex_got_data_ok), 32'd1);
        run_cycle(1'b0);
        idle_mmu();

        // Store byte at offset 3.
        drive_id(1'b1, MEM_STORE, MEM_BYTE, 32'h2003, 32'h0, 32'h0000_00AB);
        run_cycle(1'b0);
        drive_id(1'b0, MEM_NOP, MEM_BYTE, 32'd0, 32'd0, 32'd0);
        mmu_addr_ok = 1'b1; mmu_data_ok = 1'b1;
        #1;
        check_val("t2_wstrb", 32'(mmu_wstrb), 32'h8);
        check_val("t2_wdata", mmu_wdata, 32'hABAB_ABAB);
        run_cycle(1'b0);
        idle_mmu();

        // Load accepted, flushed in MEM, drain before the next load issues.
        drive_id(1'b1, MEM_LOAD_U, MEM_WORD, 32'h3000, 32'h0, 32'd0);
        run_cycle(1'b0);
        drive_id(1'b1, MEM_LOAD_U, MEM_HALF, 32'h4000, 32'h2, 32'd0);
        mmu_addr_ok = 1'b1;
        run_cycle(1'b0);
        idle_mmu();
        flush = 1'b1;
        run_cycle(1'b0);
        flush = 1'b0;
        drive_id(1'b1, MEM_LOAD_S, MEM_WORD, 32'h5000, 32'h8, 32'd0);
        run_cycle(1'b0);
        drive_id(1'b0, MEM_NOP, MEM_BYTE, 32'd0, 32'd0, 32'd0);
        check_val("t4_state", 32'(dut.state_q), 32'(S_DRAIN));
        run_cycle(1'b0);
        check_val("t4_req_drain", 32'(mmu_req), 32'd0);
        run_cycle(1'b0);
        mmu_data_ok = 1'b1;
        #1;
        check_val("t4_req_dok", 32'(mmu_req), 32'd0);
        run_cycle(1'b0);
        mmu_data_ok = 1'b0;
        #1;
        check_val("t4_req_after", 32'(mmu_req), 32'd1);
        // Asynchronous reset while the request is raised.
        resetn = 1'b0;
        #1;
        check_val("t6_req", 32'(mmu_req), 32'd0);
        check_val("t6_valid", 32'(ex_valid), 32'd0);
        check_val("t6_state", 32'(dut.state_q), 32'(S_IDLE));
        model_reset();
        @(negedge clk);
        resetn = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            sz = mem_size_t'($urandom_range(0, 2));
            b = $urandom; o = $urandom;
            a = b + o;
            if (sz == MEM_HALF) o = o - {31'd0, a[0]};
            if (sz == MEM_WORD) o = o - {30'd0, a[1:0]};
            drive_id($urandom_range(0, 3) != 0, mem_type_t'($urandom_range(0, 3)), sz, b, o, $urandom);
            flush     = ($urandom_range(0, 9) == 0);
            alu_ready = ($urandom_range(0, 4) != 0);
            mem_stall = ($urandom_range(0, 3) == 0);
            run_cycle(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_lsu_stage.md
Name: ex_lsu_stage

Overview:
- EX-stage pipeline register for the memory-capable slot. Directly upstream of the MEM stage and feeds its ex_* inputs.
- Computes the effective address and aligns store data/strobes.
- Issues the single-outstanding request to the MMU using the req/addr_ok/data_ok handshake.
- Captures same-cycle data_ok so MEM sees ex_got_data_ok. After a flush, drains any orphaned request so a late data_ok cannot corrupt a younger load.

Parameters:
none (fixed 32-bit datapath; mem_type_t/mem_size_t from the shared package)

Ports:
clk  in  1  clock
resetn  in  1  reset
flush  in  1  pipeline flush; kills EX contents
id_valid  in  1  upstream instruction valid
ex_allowin  out  1  EX can accept an instruction this cycle
id_pc  in  32  pc
id_result  in  32  non-memory result, passed through
id_dest  in  5  destination register
id_base  in  32  address base
id_offset  in  32  address offset
id_wdata  in  32  store data (unaligned, low bits)
id_mem_type  in  mem_type_t  MEM_NOP/MEM_LOAD_S/MEM_LOAD_U/MEM_STORE
id_mem_size  in  mem_size_t  MEM_BYTE/MEM_HALF/MEM_WORD
alu_ready  in  1  sibling multi-cycle unit finished for the EX instruction
mem_stall  in  1  MEM stage stall
ex_valid  out  1  EX_valid
ex_both_ready  out  1  EX instruction complete; may advance when !mem_stall
ex_pc, ex_result, ex_addr  out  32 each  to MEM
ex_dest  out  5  to MEM
ex_mem_type, ex_mem_size  out  enums  to MEM
ex_got_data_ok  out  1  data_ok arrived in the issue cycle
ex_ld_data  out  32  mmu_rdata captured in that cycle
mmu_req  out  1  request
mmu_we  out  1  store
mmu_size  out  2  0 byte, 1 half, 2 word
mmu_addr  out  32  byte address
mmu_wstrb  out  4  byte strobes
mmu_wdata  out  32  replicated store data
mmu_addr_ok  in  1  request accepted
mmu_data_ok  in  1  response (load data or store ack)
mmu_rdata  in  32  load data

Behaviour:
- Reset:
  - Asynchronous active-low resetn.
  - EX_valid=0, state=S_IDLE, all EX datapath registers 0.
  - Therefore ex_valid=0, mmu_req=0, ex_got_data_ok=0 during and after reset.
- Combinational outputs:
  - ex_addr = EX_base + EX_offset (mod 2^32). mmu_addr = ex_addr.
  - Misalignment is excluded upstream and not checked here.
- Store alignment:
  - BYTE: wdata={4{b}}, wstrb=4'b0001<<addr[1:0].
  - HALF: wdata={2{h}}, wstrb=addr[1]?1100:0011.
  - WORD: wdata as-is, wstrb=1111.
  - Loads: wstrb=0.
- Issue condition:
  - mmu_req = EX_valid && type!=NOP && alu_ready && !mem_stall && state==S_IDLE && !flush.
  - A request is therefore only raised when the instruction can advance on the same edge. The accepted request lands in MEM, which owns the later data_ok.
- Readiness:
  - ex_both_ready = alu_ready && (type==NOP || (mmu_req && mmu_addr_ok)).
  - ex_allowin = !EX_valid || (ex_both_ready && !mem_stall).
- Same-cycle response:
  - ex_got_data_ok = mmu_req && mmu_addr_ok && mmu_data_ok.
  - ex_ld_data = mmu_rdata.
- Pipeline register:
  - On a clock edge, if flush, EX_valid<=0.
  - Else if ex_allowin, EX_valid<=id_valid, and the payload is loaded when id_valid.
- mmu_req withdrawal:
  - Never withdrawn without addr_ok except on flush, or when mem_stall/alu_ready drops.
  - The MMU tolerates withdrawal before acceptance.
- FSM:
  - S_IDLE: no orphan request outstanding.
  - S_DRAIN: one accepted request whose owner was flushed, with data_ok still pending.
  - Orphan detection: a flag pend=1 is set when addr_ok is accepted and data_ok has not yet arrived (cleared on data_ok). It tracks the request now in MEM.
  - IDLE->DRAIN: flush while pend=1 and !mmu_data_ok.
  - DRAIN->IDLE: on mmu_data_ok. No issue in the data_ok cycle; issue allowed from the next cycle.
  - Flush in the same cycle as addr_ok: the request was never raised, because mmu_req is gated by !flush.
- Reset mid-operation returns to S_IDLE, pend=0. The MMU is reset by the same resetn.
- mem_stall rising after EX holds a valid load: no request issued, nothing outstanding.

Decomposition:
- Shared package holds:
  - mem_type_t, including new MEM_STORE.
  - mem_size_t.
  - MMU size encodings.
  - lsu_state_t {S_IDLE, S_DRAIN}.
- One natural sub-module: store_align (size, addr[1:0], wdata -> mmu_wdata, mmu_wstrb).

Test Plan:
1. LOAD_S WORD, base=0x1000, offset=4, addr_ok and data_ok in the same cycle -> mmu_req=1 for one cycle, mmu_addr=0x1004, ex_got_data_ok=1, ex_ld_data=rdata, EX advances.
2. STORE BYTE, base=0x2003, offset=0, wdata=0xAB -> mmu_we=1, mmu_wstrb=1000, mmu_wdata=0xABABABAB, mmu_size=0.
3. LOAD with mem_stall=1 for 3 cycles then 0, addr_ok after 2 more cycles -> no mmu_req while stalled; ex_allowin=0 throughout; advance on the addr_ok cycle.
4. Load accepted (addr_ok, no data_ok), flush next cycle, then a new load enters EX -> state=S_DRAIN, mmu_req=0 until mmu_data_ok, req rises the following cycle.
5. NOP-type op with alu_ready=0 for 4 cycles -> ex_both_ready=0, then 1; mmu_req never asserted.
6. resetn asserted low asynchronously while mmu_req=1 -> mmu_req and ex_valid drop immediately, state=S_IDLE.
